// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared word layout and sizing helpers for the async FIFO packer/unpacker pair
`timescale 1ns/1ps
package async_fifo_pkg;

  // Width of the lane-count field: holds (lanes filled - 1), so RATIO-1 must fit.
  function automatic int cnt_w_f(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Full FIFO word width: lanes, then lane count, then the last flag on top.
  function automatic int out_width_f(input int in_width, input int ratio);
    return in_width * ratio + cnt_w_f(ratio) + 1;
  endfunction

  localparam int DEF_IN_WIDTH = 8;
  localparam int DEF_RATIO    = 4;
  localparam int DEF_CNT_W    = cnt_w_f(DEF_RATIO);

  // Word layout at the default geometry; the read side decodes with this.
  typedef struct packed {
    logic                                last;
    logic [DEF_CNT_W-1:0]                cnt;
    logic [DEF_IN_WIDTH*DEF_RATIO-1:0]   lanes;
  } pkd_word_t;

  typedef logic [DEF_IN_WIDTH-1:0] lane_arr_t [DEF_RATIO];

  // Lane 0 lands in the least significant byte.
  function automatic pkd_word_t build_word(input lane_arr_t lanes,
                                           input logic [DEF_CNT_W-1:0] cnt,
                                           input logic last);
    pkd_word_t w;
    w.last  = last;
    w.cnt   = cnt;
    w.lanes = '0;
    for (int i = 0; i < DEF_RATIO; i++) begin
      w.lanes[i*DEF_IN_WIDTH +: DEF_IN_WIDTH] = lanes[i];
    end
    return w;
  endfunction

endpackage

// File: rtl/async_fifo_wr_packer_accum.sv
// rtl/async_fifo_wr_packer_accum.sv - lane accumulator holding a partial or one stalled complete word
`timescale 1ns/1ps
module wr_pack_accum
  import async_fifo_pkg::*;
#(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4,
  localparam int CNT_W     = cnt_w_f(RATIO),
  localparam int OUT_WIDTH = out_width_f(IN_WIDTH, RATIO)
) (
  input  logic                 wr_clk,
  input  logic                 rst,
  input  logic                 beat_fire,
  input  logic [IN_WIDTH-1:0]  s_data,
  input  logic                 s_last,
  input  logic                 out_free,
  output logic                 acc_done,
  output logic                 cmpl,
  output logic [OUT_WIDTH-1:0] cmpl_word,
  output logic [OUT_WIDTH-1:0] acc_word
);

  logic [IN_WIDTH*RATIO-1:0] lanes_q, lanes_d, merged;
  logic [CNT_W-1:0]          idx_q, idx_d;
  logic                      done_q, done_d;
  logic                      last_q, last_d;

  // Merge the incoming beat into its lane and decide whether it closes the word.
  always_comb begin
    merged = lanes_q;
    for (int i = 0; i < RATIO; i++) begin
      if (idx_q == CNT_W'(i)) merged[i*IN_WIDTH +: IN_WIDTH] = s_data;
    end
    cmpl      = beat_fire & ((idx_q == CNT_W'(RATIO - 1)) | s_last);
    cmpl_word = {s_last, idx_q, merged};
    acc_word  = {last_q, idx_q, lanes_q};
    acc_done  = done_q;
  end

  // Next accumulator state: restart on hand-off, park a completed word on stall, else fill.
  always_comb begin
    lanes_d = lanes_q;
    idx_d   = idx_q;
    done_d  = done_q;
    last_d  = last_q;
    if (done_q) begin
      if (out_free) begin
        lanes_d = '0;
        idx_d   = '0;
        done_d  = 1'b0;
        last_d  = 1'b0;
      end
    end else if (cmpl) begin
      if (out_free) begin
        lanes_d = '0;
        idx_d   = '0;
        last_d  = 1'b0;
      end else begin
        lanes_d = merged;
        last_d  = s_last;
        done_d  = 1'b1;
      end
    end else if (beat_fire) begin
      lanes_d = merged;
      idx_d   = idx_q + CNT_W'(1);
    end
  end

  // Accumulator registers.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      lanes_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      lanes_q <= lanes_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/async_fifo_wr_packer.sv
// rtl/async_fifo_wr_packer.sv - packs narrow beats into wide FIFO words and drives the FIFO write port
`timescale 1ns/1ps
module async_fifo_wr_packer
  import async_fifo_pkg::*;
#(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4,
  localparam int OUT_WIDTH = out_width_f(IN_WIDTH, RATIO)
) (
  input  logic                 wr_clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [IN_WIDTH-1:0]  s_data,
  input  logic                 s_last,
  input  logic                 fifo_full,
  output logic                 fifo_wr_en,
  output logic [OUT_WIDTH-1:0] fifo_wr_data
);

  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_word_q, out_word_d;
  logic                 acc_done, cmpl, beat_fire, out_free;
  logic [OUT_WIDTH-1:0] cmpl_word, acc_word;

  wr_pack_accum #(
    .IN_WIDTH (IN_WIDTH),
    .RATIO    (RATIO)
  ) u_accum (
    .wr_clk    (wr_clk),
    .rst       (rst),
    .beat_fire (beat_fire),
    .s_data    (s_data),
    .s_last    (s_last),
    .out_free  (out_free),
    .acc_done  (acc_done),
    .cmpl      (cmpl),
    .cmpl_word (cmpl_word),
    .acc_word  (acc_word)
  );

  // Handshake: input stalls only while a finished word is parked in the accumulator;
  // the output register counts as free in the same cycle it is being written out.
  always_comb begin
    s_ready      = ~rst & ~acc_done;
    beat_fire    = s_valid & s_ready;
    fifo_wr_en   = ~rst & out_valid_q & ~fifo_full;
    out_free     = ~out_valid_q | fifo_wr_en;
    fifo_wr_data = rst ? '0 : out_word_q;
  end

  // Output register load: a parked word takes priority over a freshly completed one.
  always_comb begin
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    if (out_free) begin
      if (acc_done) begin
        out_valid_d = 1'b1;
        out_word_d  = acc_word;
      end else if (cmpl) begin
        out_valid_d = 1'b1;
        out_word_d  = cmpl_word;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Output register.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
    end
  end

endmodule
